fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 162 ++++++++++++++++
 tb/tb_fetch_unit.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Purpose : single-outstanding instruction fetch FSM with redirect handling.
// Latency : 1 cycle from imem_rvalid to inst_valid; 1 cycle from redirect to new request.
// Backpr. : holds inst/inst_pc until inst_ready; holds imem_req/imem_addr until imem_ready.
//
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   imem_req/imem_addr               fetch request (word aligned) to instruction memory
//   imem_ready/imem_rvalid/rdata     memory accept and response
//   inst_valid/inst/inst_pc          instruction presented to decode
//   inst_ready                       decode consumes inst
//   redir_*                          control-flow redirect (branch/JAL/JALR)
//   misalign_err                     one-cycle pulse for a rejected misaligned target
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready,
  input  logic        redir_valid,
  input  logic        redir_is_jalr,
  input  logic [31:0] redir_pc,
  input  logic [31:0] redir_rs1,
  input  logic [31:0] redir_imm,
  output logic        misalign_err
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] r_tgt;
  logic [31:0] r_inst;
  logic [31:0] r_inst_pc;
  logic        r_inst_valid;
  logic        r_drop;
  logic        r_misalign;

  logic [31:0] w_pc_nxt;
  logic [31:0] w_tgt_nxt;
  logic        w_drop_nxt;
  logic        w_inst_valid_nxt;
  logic        w_load_inst;

  logic [31:0] w_jalr_sum;
  logic [31:0] w_target;
  logic        w_redir;
  logic        w_misalign;

  // JALR clears bit 0 of the sum; bit 1 set means the target is not word aligned.
  assign w_jalr_sum = redir_rs1 + redir_imm;
  assign w_target   = redir_is_jalr ? {w_jalr_sum[31:1], 1'b0} : (redir_pc + redir_imm);
  assign w_misalign = redir_valid & w_target[1];
  assign w_redir    = redir_valid & ~w_target[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_pc_nxt         = r_pc;
    w_tgt_nxt        = r_tgt;
    w_drop_nxt       = r_drop;
    w_inst_valid_nxt = r_inst_valid;
    w_load_inst      = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_state_nxt = S_REQ;
        if (w_redir) begin
          w_pc_nxt = w_target;
        end
      end
      S_REQ: begin
        // The request on the bus must not change; park the target and drop the reply.
        if (w_redir) begin
          w_tgt_nxt  = w_target;
          w_drop_nxt = 1'b1;
        end
        if (imem_ready) begin
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (w_redir) begin
          w_pc_nxt    = w_target;
          w_drop_nxt  = 1'b0;
          w_state_nxt = S_REQ;
        end else if (imem_rvalid) begin
          if (r_drop) begin
            w_pc_nxt    = r_tgt;
            w_drop_nxt  = 1'b0;
            w_state_nxt = S_REQ;
          end else begin
            w_load_inst      = 1'b1;
            w_inst_valid_nxt = 1'b1;
            w_state_nxt      = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        // Redirect takes priority over a same-cycle consume.
        if (w_redir) begin
          w_pc_nxt         = w_target;
          w_inst_valid_nxt = 1'b0;
          w_state_nxt      = S_REQ;
        end else if (inst_ready) begin
          w_pc_nxt         = r_pc + 32'd4;
          w_inst_valid_nxt = 1'b0;
          w_state_nxt      = S_REQ;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc         <= RESET_PC;
      r_tgt        <= RESET_PC;
      r_drop       <= 1'b0;
      r_inst_valid <= 1'b0;
      r_inst       <= NOP;
      r_inst_pc    <= RESET_PC;
      r_misalign   <= 1'b0;
    end else begin
      r_pc         <= w_pc_nxt;
      r_tgt        <= w_tgt_nxt;
      r_drop       <= w_drop_nxt;
      r_inst_valid <= w_inst_valid_nxt;
      r_misalign   <= w_misalign;
      if (w_load_inst) begin
        r_inst    <= imem_rdata;
        r_inst_pc <= r_pc;
      end
    end
  end

  assign imem_req     = (r_state == S_REQ);
  assign imem_addr    = r_pc;
  assign inst_valid   = r_inst_valid;
  assign inst         = r_inst;
  assign inst_pc      = r_inst_pc;
  assign misalign_err = r_misalign;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;
  logic        redir_valid;
  logic        redir_is_jalr;
  logic [31:0] redir_pc;
  logic [31:0] redir_rs1;
  logic [31:0] redir_imm;
  logic        misalign_err;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ready   (imem_ready),
    .imem_rvalid  (imem_rvalid),
    .imem_rdata   (imem_rdata),
    .inst_valid   (inst_valid),
    .inst         (inst),
    .inst_pc      (inst_pc),
    .inst_ready   (inst_ready),
    .redir_valid  (redir_valid),
    .redir_is_jalr(redir_is_jalr),
    .redir_pc     (redir_pc),
    .redir_rs1    (redir_rs1),
    .redir_imm    (redir_imm),
    .misalign_err (misalign_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Waits (bounded) for a request, accepts it, then returns the response one cycle later.
  // Leaves the bench at the negedge after the response cycle.
  task automatic fetch_one(input logic [31:0] data, output logic [31:0] addr_seen, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (imem_req) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    addr_seen   = imem_addr;
    imem_ready  = 1'b1;
    @(negedge clk);
    imem_ready  = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = data;
    @(negedge clk);
    imem_rvalid = 1'b0;
  endtask

  task automatic set_redir(input logic jalr, input logic [31:0] pc, input logic [31:0] rs1,
                           input logic [31:0] imm);
    redir_valid   = 1'b1;
    redir_is_jalr = jalr;
    redir_pc      = pc;
    redir_rs1     = rs1;
    redir_imm     = imm;
  endtask

  task automatic test_reset;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req got %h want 0", imem_req); end
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr got %h want 0", imem_addr); end
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %h want 0", inst_valid); end
    checks++; if (inst !== 32'h0000_0013) begin errors++; $display("FAIL reset_inst got %h want 00000013", inst); end
    checks++; if (inst_pc !== 32'h0) begin errors++; $display("FAIL reset_inst_pc got %h want 0", inst_pc); end
    checks++; if (misalign_err !== 1'b0) begin errors++; $display("FAIL reset_misalign got %h want 0", misalign_err); end
  endtask

  task automatic test_basic;
    exp_t e;
    rst_n      = 1'b1;
    imem_ready = 1'b1;
    inst_ready = 1'b1;
    @(negedge clk);
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL basic_req got %h want 1", imem_req); end
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL basic_addr got %h want 0", imem_addr); end
    exp_q.push_back('{pc: 32'h0, ins: 32'h0050_0093});
    @(negedge clk);
    imem_ready  = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h0050_0093;
    @(negedge clk);
    imem_rvalid = 1'b0;
    e = exp_q.pop_front();
    checks++; if (inst_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got %h want 1", inst_valid); end
    checks++; if (inst !== e.ins) begin errors++; $display("FAIL basic_inst got %h want %h", inst, e.ins); end
    checks++; if (inst_pc !== e.pc) begin errors++; $display("FAIL basic_inst_pc got %h want %h", inst_pc, e.pc); end
    @(negedge clk);
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin
      errors++; $display("FAIL basic_next_addr got req %h addr %h want req 1 addr 4", imem_req, imem_addr);
    end
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL basic_consumed got %h want 0", inst_valid); end
  endtask

  task automatic test_hold;
    exp_t        e;
    logic [31:0] a;
    bit          ok;
    inst_ready = 1'b0;
    exp_q.push_back('{pc: 32'h4, ins: 32'h1111_2222});
    fetch_one(32'h1111_2222, a, ok);
    checks++; if (!ok) begin errors++; $display("FAIL hold_timeout no request seen"); end
    e = exp_q.pop_front();
    checks++; if (inst_valid !== 1'b1 || inst !== e.ins || inst_pc !== e.pc) begin
      errors++; $display("FAIL hold_deliver got v %h inst %h pc %h want 1 %h %h", inst_valid, inst, inst_pc, e.ins, e.pc);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (inst_valid !== 1'b1 || inst !== e.ins || inst_pc !== e.pc || imem_req !== 1'b0) begin
        errors++;
        $display("FAIL hold_stable cyc %0d got v %h inst %h pc %h req %h want 1 %h %h 0",
                 i, inst_valid, inst, inst_pc, imem_req, e.ins, e.pc);
      end
    end
    inst_ready = 1'b1;
    @(negedge clk);
    inst_ready = 1'b0;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin
      errors++; $display("FAIL hold_next got req %h addr %h want 1 00000008", imem_req, imem_addr);
    end
  endtask

  task automatic test_redir_wait;
    imem_ready = 1'b1;
    @(negedge clk);
    imem_ready  = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hBAD0_0001;
    set_redir(1'b0, 32'h100, 32'h0, 32'hFFFF_FFF0);
    @(negedge clk);
    imem_rvalid = 1'b0;
    redir_valid = 1'b0;
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL rwait_dropped got %h want 0", inst_valid); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'hF0) begin
      errors++; $display("FAIL rwait_addr got req %h addr %h want 1 000000f0", imem_req, imem_addr);
    end
    @(negedge clk);
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL rwait_still got %h want 0", inst_valid); end
  endtask

  task automatic test_misalign;
    exp_t        e;
    logic [31:0] a;
    bit          ok;
    set_redir(1'b1, 32'h0, 32'h203, 32'h0);
    @(negedge clk);
    redir_valid = 1'b0;
    checks++; if (misalign_err !== 1'b1) begin errors++; $display("FAIL mis_pulse got %h want 1", misalign_err); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'hF0) begin
      errors++; $display("FAIL mis_ignored got req %h addr %h want 1 000000f0", imem_req, imem_addr);
    end
    @(negedge clk);
    checks++; if (misalign_err !== 1'b0) begin errors++; $display("FAIL mis_one_cycle got %h want 0", misalign_err); end
    // The ignored redirect must not have armed a drop: this response is delivered.
    exp_q.push_back('{pc: 32'hF0, ins: 32'h3333_4444});
    fetch_one(32'h3333_4444, a, ok);
    checks++; if (!ok) begin errors++; $display("FAIL mis_timeout no request seen"); end
    e = exp_q.pop_front();
    checks++; if (inst_valid !== 1'b1 || inst !== e.ins || inst_pc !== e.pc) begin
      errors++; $display("FAIL mis_deliver got v %h inst %h pc %h want 1 %h %h", inst_valid, inst, inst_pc, e.ins, e.pc);
    end
    // Aligned JALR target in HOLD, racing a consume: redirect wins.
    set_redir(1'b1, 32'h0, 32'h201, 32'h0);
    inst_ready = 1'b1;
    @(negedge clk);
    redir_valid = 1'b0;
    inst_ready  = 1'b0;
    checks++; if (inst_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h200 || misalign_err !== 1'b0) begin
      errors++; $display("FAIL jalr_target got v %h req %h addr %h mis %h want 0 1 00000200 0",
                         inst_valid, imem_req, imem_addr, misalign_err);
    end
  endtask

  task automatic test_redir_req;
    set_redir(1'b0, 32'h300, 32'h0, 32'h10);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      redir_valid = 1'b0;
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin
        errors++; $display("FAIL rreq_stable cyc %0d got req %h addr %h want 1 00000200", i, imem_req, imem_addr);
      end
      // A second redirect while the drop is pending replaces the parked target.
      if (i == 1) set_redir(1'b0, 32'h400, 32'h0, 32'h0);
    end
    imem_ready = 1'b1;
    @(negedge clk);
    imem_ready  = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hBAD0_0002;
    @(negedge clk);
    imem_rvalid = 1'b0;
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL rreq_dropped got %h want 0", inst_valid); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h400) begin
      errors++; $display("FAIL rreq_target got req %h addr %h want 1 00000400", imem_req, imem_addr);
    end
  endtask

  task automatic test_wrap;
    exp_t        e;
    logic [31:0] a;
    bit          ok;
    exp_q.push_back('{pc: 32'h400, ins: 32'h5555_6666});
    fetch_one(32'h5555_6666, a, ok);
    checks++; if (!ok) begin errors++; $display("FAIL wrap_timeout1 no request seen"); end
    e = exp_q.pop_front();
    checks++; if (inst_valid !== 1'b1 || inst !== e.ins || inst_pc !== e.pc) begin
      errors++; $display("FAIL wrap_deliver1 got v %h inst %h pc %h want 1 %h %h", inst_valid, inst, inst_pc, e.ins, e.pc);
    end
    // 0x10 + (-0x14) wraps to 0xFFFFFFFC.
    set_redir(1'b0, 32'h10, 32'h0, 32'hFFFF_FFEC);
    @(negedge clk);
    redir_valid = 1'b0;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) begin
      errors++; $display("FAIL wrap_target got req %h addr %h want 1 fffffffc", imem_req, imem_addr);
    end
    inst_ready = 1'b1;
    exp_q.push_back('{pc: 32'hFFFF_FFFC, ins: 32'h7777_8888});
    fetch_one(32'h7777_8888, a, ok);
    checks++; if (!ok) begin errors++; $display("FAIL wrap_timeout2 no request seen"); end
    e = exp_q.pop_front();
    checks++; if (inst_valid !== 1'b1 || inst !== e.ins || inst_pc !== e.pc) begin
      errors++; $display("FAIL wrap_deliver2 got v %h inst %h pc %h want 1 %h %h", inst_valid, inst, inst_pc, e.ins, e.pc);
    end
    @(negedge clk);
    inst_ready = 1'b0;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      errors++; $display("FAIL wrap_seq got req %h addr %h want 1 00000000", imem_req, imem_addr);
    end
  endtask

  task automatic test_reset_midreq;
    exp_t        e;
    logic [31:0] a;
    bit          ok;
    imem_ready = 1'b1;
    @(negedge clk);
    imem_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b0 || inst_valid !== 1'b0 || inst !== 32'h0000_0013) begin
      errors++; $display("FAIL rst_async got req %h v %h inst %h want 0 0 00000013", imem_req, inst_valid, inst);
    end
    @(negedge clk);
    rst_n       = 1'b1;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hBAD0_0003;
    @(negedge clk);
    imem_rvalid = 1'b0;
    checks++; if (inst_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      errors++; $display("FAIL rst_stale got v %h req %h addr %h want 0 1 00000000", inst_valid, imem_req, imem_addr);
    end
    exp_q.push_back('{pc: 32'h0, ins: 32'h9999_AAAA});
    fetch_one(32'h9999_AAAA, a, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rst_timeout no request seen"); end
    e = exp_q.pop_front();
    checks++; if (inst_valid !== 1'b1 || inst !== e.ins || inst_pc !== e.pc) begin
      errors++; $display("FAIL rst_deliver got v %h inst %h pc %h want 1 %h %h", inst_valid, inst, inst_pc, e.ins, e.pc);
    end
  endtask

  initial begin
    rst_n         = 1'b0;
    imem_ready    = 1'b0;
    imem_rvalid   = 1'b0;
    imem_rdata    = 32'h0;
    inst_ready    = 1'b0;
    redir_valid   = 1'b0;
    redir_is_jalr = 1'b0;
    redir_pc      = 32'h0;
    redir_rs1     = 32'h0;
    redir_imm     = 32'h0;
    @(negedge clk);
    @(negedge clk);
    test_reset();
    test_basic();
    test_hold();
    test_redir_wait();
    test_misalign();
    test_redir_req();
    test_wrap();
    test_reset_midreq();
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_left got %0d want 0", exp_q.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
